cim_acc_ctrl: RTL and testbench
===============================

# cim_acc_ctrl

Bit-serial accumulation controller for the CIM macro output path. Sequences NBITS activation bit-planes, MSB first, and accepts one PSUM_W-bit signed partial sum per plane. Folds each partial sum into an ACC_W-bit signed accumulator through the sign-extended shift-add datapath, then presents the finished dot-product result on a valid/ready output port. Sits between the macro's partial-sum adder tree and the output buffer, and drives the macro's bit-plane select.

## Interface
- NBITS, 8, activation bit-planes per operation (2..16)
- PSUM_W, 20, partial-sum width (signed two's complement)
- ACC_W, 36, accumulator/result width; ACC_W > PSUM_W
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin an operation; sampled only in IDLE
- signed_act  input  1  activations are two's complement (MSB plane weight negative); latched at start
- bit_idx  output  $clog2(NBITS)  bit-plane the macro must present now
- psum  input  PSUM_W  signed partial sum for plane bit_idx
- psum_valid  input  1  psum is valid
- psum_ready  output  1  controller accepts psum this cycle
- acc_out  output  ACC_W  signed result; stable while out_valid
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- busy  output  1  state != IDLE
- ovf  output  1  sticky: an accumulation step exceeded ACC_W signed range during this operation

## Operation
- States: IDLE, ACC, DONE.
- IDLE: psum_ready=0, out_valid=0. On start=1: acc<=0, ovf<=0, bit_idx<=NBITS-1, latch signed_act, go to ACC.
- ACC: psum_ready=1 (decoded from state only, no dependency on psum_valid). Accepted beat = psum_valid & psum_ready.
- Per accepted beat: t = 2*acc + sx(psum), where sx = sign-extension to ACC_W+2 bits. If signed_act latched and bit_idx==NBITS-1, t = 2*acc - sx(psum).
- Result width rule: t is evaluated in ACC_W+2 bits. acc <= t[ACC_W-1:0] (wrap). ovf <= ovf | (t outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]).
- After an accepted beat with bit_idx==0, go to DONE; otherwise bit_idx decrements.
- No beat accepted: acc and bit_idx hold. Gaps of any length are legal.
- DONE: out_valid=1, psum_ready=0, acc_out=acc. On out_ready=1, go to IDLE.
- start outside IDLE is ignored. A start in the same cycle DONE completes is ignored; it must be reasserted in IDLE.
- psum_valid outside ACC is ignored and never consumed.
- Reset at any time, including mid-ACC: state=IDLE, acc=0, bit_idx=0, ovf=0. Outputs: psum_ready=0, out_valid=0, busy=0, acc_out=0.

## Timing
- start sampled in cycle N; psum_ready=1 from cycle N+1.
- NBITS accepted beats, with the last in cycle M; out_valid=1 from cycle M+1.
- Minimum operation: 1 (IDLE/start) + NBITS + 1 (DONE) = NBITS+2 cycles with no stalls.
- acc_out and ovf are registered and change only on accepted beats, start, or reset.
- bit_idx is registered and valid the same cycle psum_ready is high.

## Configuration
- CIM_ACC_SAT_EN defined: each step clamps instead of wrapping. If t exceeds the maximum, acc <= 2^(ACC_W-1)-1; if t is below the minimum, acc <= -2^(ACC_W-1). ovf is still set.
- CIM_ACC_SAT_EN undefined: wrap modulo 2^ACC_W as above; ovf is flag only.

## Test plan
- NBITS=8, signed_act=0, psum=1 on all 8 beats, no stalls -> acc_out=255, ovf=0, out_valid exactly 9 cycles after start.
- signed_act=1, psum=1 on all beats -> acc_out=-1 (36'hF_FFFF_FFFF). Same test with signed_act=0 and psum=20'hFFFFF (-1) -> acc_out=-255 (36'hF_FFFF_FF01).
- Random psum_valid gaps and out_ready held low 5 cycles -> same results as no-stall run; acc_out stable and out_valid held throughout DONE; no beats lost or duplicated.
- rst_n low during beat 4, then a new operation with psum=2 on all beats -> acc_out=510, ovf=0, no residue from the aborted operation.
- ACC_W=24, signed_act=0, psum=20'h7FFFF on all 8 beats -> ovf=1. Without CIM_ACC_SAT_EN: acc_out=24'hF7FF01. With CIM_ACC_SAT_EN: acc_out=24'h7FFFFF.
- start pulsed during ACC, and psum_valid=1 during IDLE/DONE -> no state change, no psum consumed.

Source files
------------

// File: rtl/cim_acc_ctrl.sv
// -----------------------------------------------------------------------------
// cim_acc_ctrl
//
// Bit-serial accumulation controller for the CIM macro output path.
// Walks NBITS activation bit-planes MSB first and drives the plane select
// (bit_idx) to the macro. It takes one signed partial sum per plane and folds
// it into a signed accumulator as acc = 2*acc +/- psum. The finished result is
// then offered on a valid/ready output port.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. psum_ready is decoded from state only. out_valid stays
// high, and acc_out stays stable, until out_ready is seen.
//
// Optional feature: define CIM_ACC_SAT_EN to make each accumulation step
// saturate instead of wrapping. ovf is set in either build.
//
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   start         begin an operation (sampled in IDLE only)
//   signed_act    activations are two's complement (latched at start)
//   bit_idx       bit-plane the macro must present now
//   psum          signed partial sum for plane bit_idx
//   psum_valid    psum is valid
//   psum_ready    controller accepts psum this cycle
//   acc_out       signed result, stable while out_valid
//   out_valid     result available
//   out_ready     consumer takes result
//   busy          controller is not idle
//   ovf           sticky per-operation range overflow of an accumulation step
//   dbg_state     raw FSM state for observation (0 IDLE, 1 ACC, 2 DONE)
// -----------------------------------------------------------------------------
module cim_acc_ctrl #(
  parameter int NBITS  = 8,
  parameter int PSUM_W = 20,
  parameter int ACC_W  = 36,
  localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_act,
  output logic [BW-1:0]     bit_idx,
  input  logic [PSUM_W-1:0] psum,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [BW-1:0] MSB_IDX = BW'(NBITS - 1);

  state_t             state, state_nxt;
  logic               signed_q;
  logic [ACC_W-1:0]   acc;
  logic               accept;
  logic               msb_neg;

  // Step datapath, evaluated in ACC_W+2 bits so 2*acc +/- psum never loses
  // its true value before the range check.
  logic [ACC_W+1:0]   acc_x2;
  logic [ACC_W+1:0]   psum_x;
  logic [ACC_W+1:0]   t;
  logic [2:0]         t_top;
  logic               t_ovf;
  logic [ACC_W-1:0]   acc_step;

  assign accept  = psum_valid & psum_ready;
  assign msb_neg = signed_q & (bit_idx == MSB_IDX);

  assign acc_x2  = {acc[ACC_W-1], acc, 1'b0};
  assign psum_x  = {{(ACC_W + 2 - PSUM_W){psum[PSUM_W-1]}}, psum};
  assign t       = msb_neg ? (acc_x2 - psum_x) : (acc_x2 + psum_x);

  // t fits in ACC_W signed bits only when its top three bits agree.
  assign t_top   = t[ACC_W+1:ACC_W-1];
  assign t_ovf   = ~((&t_top) | ~(|t_top));

`ifdef CIM_ACC_SAT_EN
  assign acc_step = !t_ovf    ? t[ACC_W-1:0] :
                    t[ACC_W+1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                 {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_step = t[ACC_W-1:0];
`endif

  // Next-state and handshake decode
  always_comb begin
    state_nxt  = state;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ACC;
      end
      S_ACC: begin
        psum_ready = 1'b1;
        if (accept && (bit_idx == '0)) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      bit_idx  <= '0;
      ovf      <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        acc      <= '0;
        ovf      <= 1'b0;
        bit_idx  <= MSB_IDX;
        signed_q <= signed_act;
      end else if (accept) begin
        acc <= acc_step;
        ovf <= ovf | t_ovf;
        if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
      end
    end
  end

  assign acc_out   = acc;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cim_acc_ctrl.sv
module tb_cim_acc_ctrl;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_act = 1'b0;
  logic [19:0] psum = '0;
  logic        psum_valid = 1'b0;
  logic        out_ready = 1'b0;

  // Instance A: default widths. Instance B: ACC_W=24 to reach overflow.
  logic [2:0]  bit_idx_a, bit_idx_b;
  logic        psum_ready_a, psum_ready_b;
  logic [35:0] acc_out_a;
  logic [23:0] acc_out_b;
  logic        out_valid_a, out_valid_b;
  logic        busy_a, busy_b;
  logic        ovf_a, ovf_b;
  logic [1:0]  dbg_state_a, dbg_state_b;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] ps [NB];

  cim_acc_ctrl #(.NBITS(8), .PSUM_W(20), .ACC_W(36)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_act(signed_act),
    .bit_idx(bit_idx_a), .psum(psum), .psum_valid(psum_valid),
    .psum_ready(psum_ready_a), .acc_out(acc_out_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .busy(busy_a), .ovf(ovf_a), .dbg_state(dbg_state_a)
  );

  cim_acc_ctrl #(.NBITS(8), .PSUM_W(20), .ACC_W(24)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_act(signed_act),
    .bit_idx(bit_idx_b), .psum(psum), .psum_valid(psum_valid),
    .psum_ready(psum_ready_b), .acc_out(acc_out_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .busy(busy_b), .ovf(ovf_b), .dbg_state(dbg_state_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Weighted plane sum computed step by step in 64-bit integers, with the
  // range rule of a w-bit signed accumulator applied after each step.
  function automatic void model(input int w, input bit s,
                                output logic [63:0] acc_bits, output bit ov);
    longint acc, p, t, hi, lo, m;
    acc = 0;
    ov  = 1'b0;
    hi  = (64'sd1 <<< (w - 1)) - 1;
    lo  = -(64'sd1 <<< (w - 1));
    m   = 64'sd1 <<< w;
    for (int i = 0; i < NB; i++) begin
      p = longint'($signed(ps[i]));
      t = 2 * acc + ((s && i == 0) ? -p : p);
      if (t > hi || t < lo) ov = 1'b1;
`ifdef CIM_ACC_SAT_EN
      if (t > hi) acc = hi;
      else if (t < lo) acc = lo;
      else acc = t;
`else
      acc = t % m;
      if (acc > hi) acc = acc - m;
      if (acc < lo) acc = acc + m;
`endif
    end
    acc_bits = 64'(acc) & (64'(m) - 64'd1);
  endfunction

  // ---------------- reset-state check ----------------
  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},    64'(busy_a),       64'd0);
    chk({tag, "_ready"},   64'(psum_ready_a), 64'd0);
    chk({tag, "_valid"},   64'(out_valid_a),  64'd0);
    chk({tag, "_acc"},     64'(acc_out_a),    64'd0);
    chk({tag, "_ovf"},     64'(ovf_a),        64'd0);
    chk({tag, "_idx"},     64'(bit_idx_a),    64'd0);
    chk({tag, "_busy_b"},  64'(busy_b),       64'd0);
    chk({tag, "_acc_b"},   64'(acc_out_b),    64'd0);
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input string tag, input bit s, input bit gaps, input int hold);
    logic [63:0] ea, eb;
    bit oa, ob;
    model(36, s, ea, oa);
    model(24, s, eb, ob);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy_a), 64'd0);
    start = 1'b1;
    signed_act = s;
    @(negedge clk);
    start = 1'b0;
    signed_act = ~s;  // must have been latched at start
    for (int i = 0; i < NB; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          psum_valid = 1'b0;
          psum = 20'($urandom);
          start = 1'b1;  // ignored outside IDLE
          chk({tag, "_gap_rdy"}, 64'(psum_ready_a), 64'd1);
          chk({tag, "_gap_idx"}, 64'(bit_idx_a), 64'(NB - 1 - i));
          @(negedge clk);
        end
        start = 1'b0;
      end
      psum_valid = 1'b1;
      psum = ps[i];
      chk({tag, "_rdy"},   64'(psum_ready_a), 64'd1);
      chk({tag, "_idx"},   64'(bit_idx_a),    64'(NB - 1 - i));
      chk({tag, "_idx_b"}, 64'(bit_idx_b),    64'(NB - 1 - i));
      chk({tag, "_nv"},    64'(out_valid_a),  64'd0);
      @(negedge clk);
    end
    // Junk beat offered in DONE must not be consumed.
    psum = 20'($urandom);
    chk({tag, "_dv"},    64'(out_valid_a),  64'd1);
    chk({tag, "_dv_b"},  64'(out_valid_b),  64'd1);
    chk({tag, "_drdy"},  64'(psum_ready_a), 64'd0);
    chk({tag, "_acc"},   64'(acc_out_a),    ea);
    chk({tag, "_ovf"},   64'(ovf_a),        64'(oa));
    chk({tag, "_acc_b"}, 64'(acc_out_b),    eb);
    chk({tag, "_ovf_b"}, 64'(ovf_b),        64'(ob));
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_hold_v"},   64'(out_valid_a), 64'd1);
      chk({tag, "_hold_acc"}, 64'(acc_out_a),   ea);
      chk({tag, "_hold_b"},   64'(acc_out_b),   eb);
    end
    out_ready = 1'b1;
    start = 1'b1;  // coincides with DONE completing: ignored
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    psum_valid = 1'b0;
    chk({tag, "_end_busy"}, 64'(busy_a),      64'd0);
    chk({tag, "_end_v"},    64'(out_valid_a), 64'd0);
    chk({tag, "_end_acc"},  64'(acc_out_a),   ea);
    @(negedge clk);
    chk({tag, "_stay_idle"}, 64'(busy_a), 64'd0);
  endtask

  task automatic fill(input logic [19:0] v);
    for (int i = 0; i < NB; i++) ps[i] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    // psum_valid in IDLE must not start anything
    psum_valid = 1'b1;
    psum = 20'h12345;
    @(negedge clk);
    chk("idle_pv_busy", 64'(busy_a), 64'd0);
    chk("idle_pv_acc",  64'(acc_out_a), 64'd0);
    psum_valid = 1'b0;

    fill(20'h00001);  run_op("u_ones", 1'b0, 1'b0, 0);
    fill(20'h00001);  run_op("s_ones", 1'b1, 1'b0, 0);
    fill(20'hFFFFF);  run_op("u_neg1", 1'b0, 1'b0, 0);
    fill(20'h00001);  run_op("u_gap",  1'b0, 1'b1, 5);
    fill(20'h7FFFF);  run_op("u_max",  1'b0, 1'b0, 2);
    fill(20'h7FFFF);  run_op("s_max",  1'b1, 1'b1, 1);
    fill(20'h80000);  run_op("s_min",  1'b1, 1'b0, 0);

    // Reset during beat 4, then a clean operation.
    for (int i = 0; i < NB; i++) ps[i] = 20'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      psum_valid = 1'b1;
      psum = ps[i];
      if (i < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    psum_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill(20'h00002);  run_op("after_rst", 1'b0, 1'b0, 0);

    // Randomized operations
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NB; i++) ps[i] = 20'($urandom);
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
